// File: rtl/ti_sbox_pkg.sv
// Shared types and helpers for the TI S-box sequencer: FSM encoding and
// nibble addressing within share-packed vectors.
package ti_sbox_pkg;

  localparam int NIBBLE_W  = 4;
  localparam int VEC_MAX_W = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fsm_state_t;

  // Nibble 'index' of share 'share' when every share is 'nibbles' nibbles wide.
  function automatic logic [NIBBLE_W-1:0] share_nibble(
    input logic [VEC_MAX_W-1:0] vec,
    input int                   share,
    input int                   index,
    input int                   nibbles = 1
  );
    return vec[(share * nibbles + index) * NIBBLE_W +: NIBBLE_W];
  endfunction

endpackage

// File: rtl/ti_sbox_sequencer_if.sv
// Signal bundle between the round-state logic, the sequencer and the
// external TI S-box component functions.
interface ti_sbox_sequencer_if #(
  parameter int NIBBLES = 16,
  parameter int SHARES  = 3
);
  localparam int STATE_W = SHARES * 4 * NIBBLES;
  localparam int SLICE_W = SHARES * 4;

  // start is a request sampled only while idle; done is a one-cycle pulse,
  // and state_out holds from done until the next accepted start.
  logic               start;
  logic [STATE_W-1:0] state_in;
  logic               busy;
  logic               done;
  logic [STATE_W-1:0] state_out;
  logic [SLICE_W-1:0] sb_a_in;
  logic [SLICE_W-1:0] sb_a_out;
  logic [SLICE_W-1:0] sb_b_in;
  logic [SLICE_W-1:0] sb_b_out;

  modport master (
    output start, state_in, sb_a_out, sb_b_out,
    input  busy, done, state_out, sb_a_in, sb_b_in
  );

  modport slave (
    input  start, state_in, sb_a_out, sb_b_out,
    output busy, done, state_out, sb_a_in, sb_b_in
  );

endinterface

// File: rtl/ti_nibble_shreg.sv
// Nibble-wide right shift register with parallel load and synchronous clear;
// new nibbles enter at the top.
module ti_nibble_shreg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_d,
  input  logic         shift,
  input  logic [3:0]   shift_in,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_d;
    end else if (shift) begin
      q <= {shift_in, q[W-1:4]};
    end
  end

endmodule

// File: rtl/ti_sbox_sequencer.sv
// Streams a masked state one nibble per cycle through an external two-stage
// TI S-box, keeping the glitch-isolation register between the stages.
module ti_sbox_sequencer
  import ti_sbox_pkg::*;
#(
  parameter int NIBBLES = 16,
  parameter int SHARES  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  ti_sbox_sequencer_if.slave     bus,
  output fsm_state_t             dbg_state
);

  localparam int SHARE_W = NIBBLE_W * NIBBLES;
  localparam int SLICE_W = NIBBLE_W * SHARES;
  localparam int CNT_W   = $clog2(NIBBLES + 1);

  fsm_state_t         state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [SLICE_W-1:0] mid, mid_nx;
  logic               mid_vld, mid_vld_nx;
  logic               accept;
  logic               shift_en;
  logic               run;
  logic [SLICE_W-1:0] sb_a_nib;
  logic [SHARE_W-1:0] sreg_q [SHARES];
  logic [SHARE_W-1:0] res_q  [SHARES];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mid     <= '0;
      mid_vld <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      mid     <= mid_nx;
      mid_vld <= mid_vld_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    mid_nx     = mid;
    mid_vld_nx = mid_vld;
    accept     = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          cnt_nx   = '0;
          state_nx = RUN;
        end
      end
      RUN: begin
        shift_en   = 1'b1;
        mid_nx     = bus.sb_a_out;
        mid_vld_nx = 1'b1;
        cnt_nx     = cnt + 1'b1;
        if (cnt == CNT_W'(NIBBLES - 1)) state_nx = DRAIN;
      end
      DRAIN: begin
        // The last stage-1 result is consumed this cycle; clear mid so
        // stage 2 sees zeros from DONE onwards.
        mid_vld_nx = 1'b0;
        mid_nx     = '0;
        state_nx   = DONE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  for (genvar s = 0; s < SHARES; s++) begin : g_share
    ti_nibble_shreg #(.W(SHARE_W)) u_sreg (
      .clk      (clk),
      .rst      (rst),
      .clr      (1'b0),
      .load     (accept),
      .load_d   (bus.state_in[s*SHARE_W +: SHARE_W]),
      .shift    (shift_en),
      .shift_in (4'h0),
      .q        (sreg_q[s])
    );

    ti_nibble_shreg #(.W(SHARE_W)) u_res (
      .clk      (clk),
      .rst      (rst),
      .clr      (1'b0),
      .load     (1'b0),
      .load_d   ({SHARE_W{1'b0}}),
      .shift    (mid_vld),
      .shift_in (share_nibble(VEC_MAX_W'(bus.sb_b_out), s, 0)),
      .q        (res_q[s])
    );

    assign sb_a_nib[s*NIBBLE_W +: NIBBLE_W]      = sreg_q[s][NIBBLE_W-1:0];
    assign bus.state_out[s*SHARE_W +: SHARE_W]   = res_q[s];
  end

  // Stage-1 inputs are forced to zero unless the registered state is RUN.
  assign run         = (state == RUN);
  assign bus.sb_a_in = run ? sb_a_nib : '0;
  assign bus.sb_b_in = mid;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == DONE);
  assign dbg_state   = state;

endmodule

// File: doc/ti_sbox_sequencer.md
# ti_sbox_sequencer

Controller that runs a full masked state through one shared two-stage threshold-implementation (TI) 4-bit S-box, one nibble per cycle. The S-box component functions stay outside this block. It drives their inputs from registered state, holds the mandatory glitch-isolation register between stage 1 and stage 2, and collects stage-2 outputs into a result register. It sits between the round-state register and the TI S-box layer in the lightweight cipher core.

## Interface
- NIBBLES, 16: nibbles per share of the state.
- SHARES, 3: number of Boolean shares (TI, non-complete component functions).
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- state_in  in  SHARES*4*NIBBLES  masked input state; share s occupies bits [s*4*NIBBLES +: 4*NIBBLES]. Captured when start is accepted.
- busy  out  1  high in RUN, DRAIN and DONE.
- done  out  1  one-cycle pulse; state_out valid from this cycle until the next accepted start.
- state_out  out  SHARES*4*NIBBLES  substituted masked state, same packing as state_in.
- sb_a_in  out  SHARES*4  current nibble of every share, to the stage-1 component functions.
- sb_a_out  in  SHARES*4  stage-1 result (combinational external).
- sb_b_in  out  SHARES*4  registered stage-1 result, to the stage-2 component functions.
- sb_b_out  in  SHARES*4  stage-2 result (combinational external).

## Operation
- Registers:
  - sreg: captured state.
  - mid: SHARES*4 bits, plus mid_vld.
  - res: the state_out register.
  - cnt: width $clog2(NIBBLES+1).
  - FSM.
- FSM states are IDLE, RUN, DRAIN, DONE.
  - IDLE: if start=1, then sreg<=state_in, cnt<=0, move to RUN.
  - RUN:
    - sb_a_in = low nibble of each share of sreg.
    - sreg shifts right 4 within each share, zero-filled.
    - mid<=sb_a_out, mid_vld<=1.
    - cnt increments; after cnt=NIBBLES-1, move to DRAIN.
  - DRAIN: mid_vld<=0, move to DONE.
  - DONE: done=1; next state IDLE unconditionally.
- Result capture:
  - On every edge where mid_vld=1, each share of res <= {sb_b_out nibble, res_share>>4}.
  - This gives exactly NIBBLES writes, so nibble 0 ends up at the lowest position of each share.
- sb_b_in = mid.
- Zero gating:
  - sb_a_in is AND-gated with the registered RUN flag, so it is all-zero outside RUN.
  - mid is cleared on entry to DONE, so sb_b_in is zero in DONE and IDLE.
- start is ignored in RUN, DRAIN and DONE; there is no queueing.
- Share ordering and share count are preserved; the block never combines shares.

## Timing
- Start sampled at edge E0:
  - RUN occupies cycles 1..NIBBLES.
  - DRAIN is cycle NIBBLES+1.
  - done=1 in cycle NIBBLES+2, i.e. 18 for NIBBLES=16.
- Minimum start-to-start spacing is NIBBLES+3 cycles. A start held high through DONE is accepted at the first IDLE edge.
- Pipeline: sb_b_in in cycle k+1 equals sb_a_out sampled at the end of cycle k. The external datapath sees exactly one register between its two stages.
- Reset values, applied at any clk edge with rst=1, including mid-RUN:
  - FSM=IDLE.
  - sreg, mid, mid_vld, res, cnt all zero.
  - busy=0, done=0, state_out=0, sb_a_in=0, sb_b_in=0 from the next cycle.
  - A partially processed state is discarded; no done is produced.
- rst and start high together: rst wins.

## Structure
- Shared package ti_sbox_pkg holds:
  - NIBBLE_W=4.
  - The FSM state enum (IDLE, RUN, DRAIN, DONE).
  - The helper function share_nibble(vector, share, index) for packing.
- One sub-module, ti_nibble_shreg:
  - Parameterized 4*NIBBLES shift register with load, shift-in nibble and synchronous clear.
  - Instantiated once per share for sreg and once per share for res.

## Test plan
- Loopback: bench ties sb_a_out=sb_a_in and sb_b_out=sb_b_in. Input share0=64'h0123456789ABCDEF, share1=64'hFFFF0000FFFF0000, share2=0; start at E0. Expect done only in cycle 18, and state_out equal to state_in in all shares.
- Order check: bench stage 1 adds 1 mod 16 to the share-0 nibble; stage 2 is identity. Input share0=64'h0123456789ABCDEF gives share0 out = 64'h123456789ABCDEF0, with shares 1 and 2 unchanged.
- Pipeline spacing: in every RUN cycle k≥2, assert sb_b_in equals the previous cycle's sb_a_out. Assert sb_a_in=0 in IDLE, DRAIN and DONE, and sb_b_in=0 in IDLE and DONE.
- Busy handling: pulse start in RUN cycle 5 and in DRAIN; both are ignored and exactly one done is produced. Hold start high through DONE; the second run is accepted at the following IDLE edge and its done arrives NIBBLES+3 cycles after the first done.
- Reset mid-operation: assert rst in RUN with cnt=5. Next cycle busy=0, done=0, state_out=0, sb_a_in=0. A fresh start then completes loopback correctly.
- Reset/start collision: rst=1 and start=1 on the same edge leaves FSM=IDLE and busy=0; no run begins.
